chest_ls_avg_reader: RTL and testbench

Read-side sequencer for the channel-estimation LS register file. After the signed complex multiplier has written its four per-NRS least-squares estimates (addresses 0..3), this block drives `rd_addr` to fetch them. It produces rounded per-symbol and whole-slot averages of the real and imaginary parts. The result feeds the equalizer.

---
 rtl/chest_ls_avg_reader.sv | 97 +++++++++
 tb/tb_chest_ls_avg_reader.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/chest_ls_avg_reader.sv
// chest_ls_avg_reader: sequences reads of the four LS estimates and registers
// rounded per-symbol and whole-slot averages of the real and imaginary parts.
module chest_ls_avg_reader #(
  parameter int WIDTH_R_I = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic [1:0]             rd_addr,
  input  logic signed [WIDTH_R_I:0] real_part_reg,
  input  logic signed [WIDTH_R_I:0] imag_part_reg,
  output logic                   busy,
  output logic                   valid,
  output logic signed [WIDTH_R_I:0] h_sym0_r,
  output logic signed [WIDTH_R_I:0] h_sym0_i,
  output logic signed [WIDTH_R_I:0] h_sym1_r,
  output logic signed [WIDTH_R_I:0] h_sym1_i,
  output logic signed [WIDTH_R_I:0] h_avg_r,
  output logic signed [WIDTH_R_I:0] h_avg_i
);
  localparam int EW = WIDTH_R_I + 1;
  typedef enum logic [1:0] {IDLE, READ, FINISH} state_t;
  state_t state;
  logic signed [EW:0] s0_r, s0_i, s1_r, s1_i;
  logic signed [EW+1:0] tot_r, tot_i;
  // Pair mean: (a + b + 1) >>> 1, kept signed so the shift is arithmetic.
  function automatic logic signed [EW-1:0] rnd_pair(input logic signed [EW:0] s);
    logic signed [EW:0] t;
    t = s + signed'({{EW{1'b0}}, 1'b1});
    t = t >>> 1;
    return t[EW-1:0];
  endfunction
  function automatic logic signed [EW-1:0] rnd_quad(input logic signed [EW+1:0] s);
    logic signed [EW+1:0] t;
    t = s + signed'({{EW{1'b0}}, 2'b10});
    t = t >>> 2;
    return t[EW-1:0];
  endfunction
  always_comb begin
    tot_r = {s0_r[EW], s0_r} + {s1_r[EW], s1_r};
    tot_i = {s0_i[EW], s0_i} + {s1_i[EW], s1_i};
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state    <= IDLE;
      rd_addr  <= 2'd0;
      busy     <= 1'b0;
      valid    <= 1'b0;
      s0_r     <= '0;
      s0_i     <= '0;
      s1_r     <= '0;
      s1_i     <= '0;
      h_sym0_r <= '0;
      h_sym0_i <= '0;
      h_sym1_r <= '0;
      h_sym1_i <= '0;
      h_avg_r  <= '0;
      h_avg_i  <= '0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE:
          if (start) begin
            state   <= READ;
            busy    <= 1'b1;
            rd_addr <= 2'd0;
            s0_r    <= '0;
            s0_i    <= '0;
            s1_r    <= '0;
            s1_i    <= '0;
          end
        READ: begin
          if (rd_addr[1]) begin
            s1_r <= s1_r + {real_part_reg[EW-1], real_part_reg};
            s1_i <= s1_i + {imag_part_reg[EW-1], imag_part_reg};
          end else begin
            s0_r <= s0_r + {real_part_reg[EW-1], real_part_reg};
            s0_i <= s0_i + {imag_part_reg[EW-1], imag_part_reg};
          end
          rd_addr <= rd_addr + 2'd1;
          state   <= (rd_addr == 2'd3) ? FINISH : READ;
        end
        FINISH: begin
          h_sym0_r <= rnd_pair(s0_r);
          h_sym0_i <= rnd_pair(s0_i);
          h_sym1_r <= rnd_pair(s1_r);
          h_sym1_i <= rnd_pair(s1_i);
          h_avg_r  <= rnd_quad(tot_r);
          h_avg_i  <= rnd_quad(tot_i);
          valid    <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_chest_ls_avg_reader.sv
// tb_chest_ls_avg_reader: directed vector table plus handshake and reset corner sequences.
module tb_chest_ls_avg_reader;
  localparam int W = 16;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic [1:0] rd_addr;
  logic signed [W:0] real_part_reg, imag_part_reg;
  logic busy, valid;
  logic signed [W:0] h_sym0_r, h_sym0_i, h_sym1_r, h_sym1_i, h_avg_r, h_avg_i;
  logic signed [W:0] re [4];
  logic signed [W:0] im [4];
  int errors = 0, checks = 0;
  typedef struct {
    string name;
    int re[4];
    int im[4];
    int e[6];
  } vec_t;
  vec_t tbl[5];
  chest_ls_avg_reader #(.WIDTH_R_I(W)) dut (
    .clk(clk), .rst(rst), .start(start), .rd_addr(rd_addr),
    .real_part_reg(real_part_reg), .imag_part_reg(imag_part_reg),
    .busy(busy), .valid(valid),
    .h_sym0_r(h_sym0_r), .h_sym0_i(h_sym0_i), .h_sym1_r(h_sym1_r),
    .h_sym1_i(h_sym1_i), .h_avg_r(h_avg_r), .h_avg_i(h_avg_i)
  );
  // Combinational register-file model addressed by the DUT.
  assign real_part_reg = re[rd_addr];
  assign imag_part_reg = im[rd_addr];
  always #5 clk = ~clk;
  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask
  task automatic chk_out(input vec_t v);
    chk({v.name, ".sym0_r"}, int'(h_sym0_r), v.e[0]);
    chk({v.name, ".sym1_r"}, int'(h_sym1_r), v.e[1]);
    chk({v.name, ".avg_r"}, int'(h_avg_r), v.e[2]);
    chk({v.name, ".sym0_i"}, int'(h_sym0_i), v.e[3]);
    chk({v.name, ".sym1_i"}, int'(h_sym1_i), v.e[4]);
    chk({v.name, ".avg_i"}, int'(h_avg_i), v.e[5]);
  endtask
  task automatic chk_zero(input string n);
    chk({n, ".sym0_r"}, int'(h_sym0_r), 0);
    chk({n, ".sym1_r"}, int'(h_sym1_r), 0);
    chk({n, ".avg_r"}, int'(h_avg_r), 0);
    chk({n, ".sym0_i"}, int'(h_sym0_i), 0);
    chk({n, ".sym1_i"}, int'(h_sym1_i), 0);
    chk({n, ".avg_i"}, int'(h_avg_i), 0);
  endtask
  task automatic load(input vec_t v);
    for (int i = 0; i < 4; i++) begin
      re[i] = (W+1)'(v.re[i]);
      im[i] = (W+1)'(v.im[i]);
    end
  endtask
  // One full pass; returns at the negedge inside the valid cycle.
  task automatic do_pass(input vec_t v);
    @(negedge clk);
    load(v);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk({v.name, ".rd_addr"}, int'(rd_addr), k);
      chk({v.name, ".busy_read"}, int'(busy), 1);
      chk({v.name, ".valid_early"}, int'(valid), 0);
      @(negedge clk);
    end
    chk({v.name, ".rd_addr_finish"}, int'(rd_addr), 0);
    chk({v.name, ".busy_finish"}, int'(busy), 1);
    chk({v.name, ".valid_finish"}, int'(valid), 0);
    @(negedge clk);
    chk({v.name, ".valid_lat5"}, int'(valid), 1);
    chk({v.name, ".busy_valid"}, int'(busy), 0);
    chk_out(v);
  endtask
  initial begin
    tbl[0].name = "nominal";
    tbl[0].re = '{100, 101, -3, -4};
    tbl[0].im = '{7, -8, 0, 1};
    tbl[0].e  = '{101, -3, 49, 0, 1, 0};
    tbl[1].name = "max";
    tbl[1].re = '{65535, 65535, 65535, 65535};
    tbl[1].im = '{65535, 65535, 65535, 65535};
    tbl[1].e  = '{65535, 65535, 65535, 65535, 65535, 65535};
    tbl[2].name = "min";
    tbl[2].re = '{-65536, -65536, -65536, -65536};
    tbl[2].im = '{-65536, -65536, -65536, -65536};
    tbl[2].e  = '{-65536, -65536, -65536, -65536, -65536, -65536};
    tbl[3].name = "round";
    tbl[3].re = '{-1, -2, 1, 2};
    tbl[3].im = '{-1, -2, 1, 2};
    tbl[3].e  = '{-1, 2, 0, -1, 2, 0};
    tbl[4].name = "mix";
    tbl[4].re = '{1000, -1, 0, 3};
    tbl[4].im = '{-100, -101, 50, 51};
    tbl[4].e  = '{500, 2, 251, -100, 51, -25};
    for (int i = 0; i < 4; i++) begin
      re[i] = '0;
      im[i] = '0;
    end
    repeat (30) @(negedge clk);
    chk("reset.rd_addr", int'(rd_addr), 0);
    chk("reset.busy", int'(busy), 0);
    chk("reset.valid", int'(valid), 0);
    chk_zero("reset");
    rst = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("idle.valid", int'(valid), 0);
      chk("idle.busy", int'(busy), 0);
    end
    chk_zero("idle");
    for (int t = 0; t < 5; t++) do_pass(tbl[t]);
    // start held high: a new pass begins in the IDLE cycle that carries valid
    @(negedge clk);
    load(tbl[0]);
    start = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("held.valid", int'(valid), int'(i == 5 || i == 11));
      if (i < 4) chk("held.rd_addr0", int'(rd_addr), i);
      if (i >= 6 && i < 10) chk("held.rd_addr1", int'(rd_addr), i - 6);
      if (i == 10) chk("held.rd_addr_wrap", int'(rd_addr), 0);
    end
    start = 1'b0;
    chk_out(tbl[0]);
    // start pulse during READ is ignored
    @(negedge clk);
    load(tbl[3]);
    start = 1'b1;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      start = (i == 1) ? 1'b1 : 1'b0;
      chk("ignore.valid", int'(valid), int'(i == 5));
      if (i > 5) chk("ignore.busy", int'(busy), 0);
      if (i == 5) chk_out(tbl[3]);
    end
    // reset while rd_addr is 2 aborts the pass
    do_pass(tbl[4]);
    @(negedge clk);
    load(tbl[0]);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort.rd_addr_pre", int'(rd_addr), 2);
    rst = 1'b0;
    #1;
    chk("abort.rd_addr", int'(rd_addr), 0);
    chk("abort.busy", int'(busy), 0);
    chk("abort.valid", int'(valid), 0);
    chk_zero("abort");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("abort.no_valid", int'(valid), 0);
    end
    do_pass(tbl[3]);
    do_pass(tbl[4]);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
